// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage immediate-to-instruction-field encoder; IMM_CHECK_EN adds range checks and error counter
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      field,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  logic        s1_valid;
  logic [2:0]  s1_src;
  logic [31:0] s1_imm;
  logic [24:0] s1_field;
  logic        s2_valid;
  logic [24:0] s2_field;
  logic        s1_load;
  logic        s2_load;

  // S2 frees up when empty or drained; S1 can refill whenever S2 takes its entry
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign field     = s2_field;

  // S1: capture the raw request on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src   <= 3'b000;
      s1_imm   <= 32'h0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src <= imm_src;
        s1_imm <= imm;
      end
    end
  end

  // Scatter immediate bits into instruction bits [31:7]; field index = instr bit - 7
  always_comb begin
    s1_field = 25'h0;
    case (s1_src)
      SRC_I: s1_field[24:13] = s1_imm[11:0];
      SRC_S: begin
        s1_field[24:18] = s1_imm[11:5];
        s1_field[4:0]   = s1_imm[4:0];
      end
      SRC_B: begin
        s1_field[24]    = s1_imm[12];
        s1_field[23:18] = s1_imm[10:5];
        s1_field[4:1]   = s1_imm[4:1];
        s1_field[0]     = s1_imm[11];
      end
      SRC_J: begin
        s1_field[24]    = s1_imm[20];
        s1_field[23:14] = s1_imm[10:1];
        s1_field[13]    = s1_imm[11];
        s1_field[12:5]  = s1_imm[19:12];
      end
      SRC_U: s1_field[24:5] = s1_imm[31:12];
      default: s1_field = 25'h0;
    endcase
  end

  // S2: hold the encoded field until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_field <= 25'h0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_field <= s1_field;
    end
  end

`ifdef IMM_CHECK_EN
  logic             s1_err;
  logic             s2_err;
  logic [CNT_W-1:0] cnt_q;

  // A value is representable when all bits above the format's sign bit copy it
  always_comb begin
    s1_err = 1'b0;
    case (s1_src)
      SRC_I, SRC_S: s1_err = (s1_imm[31:11] != {21{s1_imm[31]}});
      SRC_B:        s1_err = (s1_imm[31:12] != {20{s1_imm[31]}}) || s1_imm[0];
      SRC_J:        s1_err = (s1_imm[31:20] != {12{s1_imm[31]}}) || s1_imm[0];
      SRC_U:        s1_err = |s1_imm[11:0];
      default:      s1_err = 1'b1;
    endcase
  end

  // Error flag travels with its field through S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_err <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_err <= s1_err;
    end
  end

  // Count errored results as they are delivered, sticking at full scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (s2_valid && out_ready && s2_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err       = s2_err;
  assign err_count = cnt_q;
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder for the multi-cycle core's instruction assembly and self-test path. It takes a 32-bit immediate value and an immediate-type code and scatters the bits into the 25-bit instruction field (instruction bits [31:7]), using exactly the layout the immediate extender decodes. It also flags values the chosen format cannot represent. It sits between the test-program generator and the instruction memory writer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an input request is present.
- in_ready  output  1  the encoder accepts the request this cycle.
- imm_src  input  3  format code: 000 I, 001 S, 010 B, 011 J, 100 U; other codes are invalid.
- imm  input  32  immediate value to encode.
- out_valid  output  1  an encoded result is present.
- out_ready  input  1  the consumer takes the result this cycle.
- field  output  25  encoded instruction bits [31:7].
- err  output  1  the result is not representable in the chosen format.
- err_count  output  CNT_W  number of errored results delivered, saturating.

## Operation
Field mapping (field bits not listed are 0):
- I: field[24:13] = imm[11:0].
- S: field[24:18] = imm[11:5]; field[4:0] = imm[4:0].
- B: field[24] = imm[12]; field[0] = imm[11]; field[23:18] = imm[10:5]; field[4:1] = imm[4:1].
- J: field[24] = imm[20]; field[12:5] = imm[19:12]; field[13] = imm[11]; field[23:14] = imm[10:1].
- U: field[24:5] = imm[31:12].
- Invalid code: field = 0 and err = 1.

Representability, with the err condition for each format:
- I and S: imm[31:11] are not all equal.
- B: imm[31:12] are not all equal, or imm[0] = 1.
- J: imm[31:20] are not all equal, or imm[0] = 1.
- U: imm[11:0] is not 0.
- When err = 1, field still carries the truncated mapping, except for invalid codes.

Pipeline:
- S1 registers imm_src and imm and computes field and err combinationally.
- S2 holds field and err and drives the outputs.
- Each stage has its own valid bit.
- S2 loads when it is empty or out_ready = 1.
- S1 loads when it is empty or S2 is loading from it.
- in_ready = !s1_valid || s2_load. This is a combinational path from out_ready.

err_count:
- Increments by 1 on every out_valid && out_ready && err.
- Holds at 2^CNT_W - 1 once saturated.

## Timing
- Reset values: in_ready = 1, out_valid = 0, field = 0, err = 0, err_count = 0; both stage valid bits are 0.
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1, provided out_ready stays high.
- Throughput: one result per cycle under continuous ready.
- Buffering: while out_ready = 0, up to 2 results are buffered, then in_ready = 0. Order is preserved and nothing is dropped or duplicated.
- Stability: field and err stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous accept and deliver: with the pipe full, out_ready = 1 and in_valid = 1 in the same cycle, the pipe shifts and accepts the new request in that cycle.
- Reset mid-operation: rst discards all in-flight entries immediately (asynchronously) and clears err_count. Handshakes restart on the first edge after rst deasserts.

## Configuration
- IMM_CHECK_EN defined: the representability checks above are active, err is driven, and err_count counts.
- IMM_CHECK_EN undefined: err is tied to 0 and err_count is tied to 0 with no counter register. Invalid codes still produce field = 0. The field mapping and handshake behaviour are identical in both builds.

## Test plan
- I, imm = 0xFFFFF800, out_ready held high -> field = 0x1000000, err = 0, out_valid high exactly after the 2nd edge following accept.
- B, imm = 0x00000FFE -> field = 0x0FC001F, err = 0; then B, imm = 0x00001001 -> err = 1, err_count = 1.
- U, imm = 0x12345000 -> field = 0x02468A0, err = 0; then U, imm = 0x12345001 -> err = 1.
- J, imm = 0x00000003 and imm_src = 111 back to back -> both give err = 1 (the invalid code also gives field = 0), err_count = 2. Without IMM_CHECK_EN: err = 0 and err_count = 0 for both.
- Backpressure: out_ready = 0 for 4 cycles with in_valid held high and requests A, B, C -> only A and B accepted, in_ready = 0 until out_ready rises, then A, B, C delivered in order with no gaps.
- rst pulsed while 2 entries are in flight -> out_valid = 0 and err_count = 0 immediately; the next request encodes correctly with latency 2.
